// File: rtl/if_result_collector.sv
// Windowed sum/min/max/count collector for the IfEnt XOUT stream, one record per window.
// Define IF_COLLECT_SATURATE_EN to clamp the running sum at 2**NACC-1 instead of wrapping.
module if_result_collector #(
    parameter int NX     = 16,
    parameter int NACC   = 24,
    parameter int WINDOW = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [NX-1:0]                 XIN,
    input  logic                          XIN_VALID,
    output logic                          XIN_READY,
    input  logic                          FLUSH,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [NACC-1:0]               SUM,
    output logic [NX-1:0]                 VMIN,
    output logic [NX-1:0]                 VMAX,
    output logic [$clog2(WINDOW+1)-1:0]   COUNT,
    output logic                          OVF
);

    localparam int CW = $clog2(WINDOW+1);

    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]      state;

    logic [NACC-1:0] run_sum;
    logic [NX-1:0]   run_min;
    logic [NX-1:0]   run_max;
    logic [CW-1:0]   run_cnt;
    logic            run_ovf;

    logic [NACC-1:0] sum_p1;
    logic [NX-1:0]   vmin_p1;
    logic [NX-1:0]   vmax_p1;
    logic [CW-1:0]   count_p1;
    logic            ovf_p1;
    logic            vld_p1;

    logic            accept;
    logic            close;
    logic [NACC:0]   add_res;
    logic [NACC-1:0] acc_sum;
    logic [NX-1:0]   acc_min;
    logic [NX-1:0]   acc_max;
    logic [CW-1:0]   acc_cnt;
    logic            acc_ovf;

    // Returns {carry, sum}; the carry is the raw carry out of bit NACC-1 in both modes.
    function automatic logic [NACC:0] add_sample(input logic [NACC-1:0] acc,
                                                 input logic [NX-1:0]   x);
        logic [NACC:0] s;
        s = {1'b0, acc} + (NACC+1)'(x);
`ifdef IF_COLLECT_SATURATE_EN
        if (s[NACC]) s = {1'b1, {NACC{1'b1}}};
`endif
        return s;
    endfunction

    assign XIN_READY = (state == ACC);
    assign accept    = (state == ACC) && XIN_VALID;

    always_comb begin
        add_res = add_sample(run_sum, XIN);
        acc_sum = run_sum;
        acc_min = run_min;
        acc_max = run_max;
        acc_cnt = run_cnt;
        acc_ovf = run_ovf;
        if (accept) begin
            acc_sum = add_res[NACC-1:0];
            acc_ovf = run_ovf | add_res[NACC];
            acc_min = (XIN < run_min) ? XIN : run_min;
            acc_max = (XIN > run_max) ? XIN : run_max;
            acc_cnt = run_cnt + CW'(1);
        end
        // acc_cnt already includes a same-cycle sample, covering both flush cases
        close = (state == ACC) &&
                ((accept && (acc_cnt == CW'(WINDOW))) || (FLUSH && (acc_cnt != '0)));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ACC;
            run_sum  <= '0;
            run_min  <= '1;
            run_max  <= '0;
            run_cnt  <= '0;
            run_ovf  <= 1'b0;
            sum_p1   <= '0;
            vmin_p1  <= '0;
            vmax_p1  <= '0;
            count_p1 <= '0;
            ovf_p1   <= 1'b0;
            vld_p1   <= 1'b0;
        end else if (state == ACC) begin
            if (close) begin
                sum_p1   <= acc_sum;
                vmin_p1  <= acc_min;
                vmax_p1  <= acc_max;
                count_p1 <= acc_cnt;
                ovf_p1   <= acc_ovf;
                vld_p1   <= 1'b1;
                run_sum  <= '0;
                run_min  <= '1;
                run_max  <= '0;
                run_cnt  <= '0;
                run_ovf  <= 1'b0;
                state    <= HOLD;
            end else if (accept) begin
                run_sum  <= acc_sum;
                run_min  <= acc_min;
                run_max  <= acc_max;
                run_cnt  <= acc_cnt;
                run_ovf  <= acc_ovf;
            end
        end else begin
            // Record stays frozen until the downstream stage takes it
            if (OUT_READY) begin
                vld_p1 <= 1'b0;
                state  <= ACC;
            end
        end
    end

    assign OUT_VALID = vld_p1;
    assign SUM       = sum_p1;
    assign VMIN      = vmin_p1;
    assign VMAX      = vmax_p1;
    assign COUNT     = count_p1;
    assign OVF       = ovf_p1;

endmodule

// File: tb/tb_if_result_collector.sv
// Self-checking bench for if_result_collector: directed scenarios plus a randomized run
// against a window-level reference model.
module tb_if_result_collector;

    localparam int NX     = 16;
    localparam int NACC   = 17;
    localparam int WINDOW = 4;
    localparam int CW     = $clog2(WINDOW+1);
    localparam int RW     = 1 + NACC + NX + NX + CW + 1;

`ifdef IF_COLLECT_SATURATE_EN
    localparam logic [NACC-1:0] OVF4_SUM = 17'd131071;
`else
    localparam logic [NACC-1:0] OVF4_SUM = 17'd131068;
`endif

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [NX-1:0]   XIN;
    logic            XIN_VALID;
    logic            XIN_READY;
    logic            FLUSH;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [NACC-1:0] SUM;
    logic [NX-1:0]   VMIN;
    logic [NX-1:0]   VMAX;
    logic [CW-1:0]   COUNT;
    logic            OVF;

    int tests_run    = 0;
    int tests_failed = 0;
    int win[$];

    if_result_collector #(.NX(NX), .NACC(NACC), .WINDOW(WINDOW)) dut (
        .CLK(CLK), .RST_N(RST_N), .XIN(XIN), .XIN_VALID(XIN_VALID), .XIN_READY(XIN_READY),
        .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .SUM(SUM),
        .VMIN(VMIN), .VMAX(VMAX), .COUNT(COUNT), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [NX-1:0] x, input logic f, input logic r);
        XIN_VALID = v;
        XIN       = x;
        FLUSH     = f;
        OUT_READY = r;
    endtask

    function automatic logic [RW-1:0] observed();
        return {OUT_VALID, SUM, VMIN, VMAX, COUNT, OVF};
    endfunction

    function automatic logic [RW-1:0] rec(input longint s, input int mn, input int mx,
                                          input int c, input bit o);
        return {1'b1, NACC'(s), NX'(mn), NX'(mx), CW'(c), o};
    endfunction

    // Summary of the samples queued in win, following the window arithmetic rules
    function automatic logic [RW-1:0] summarize();
        longint lim = (longint'(1) << NACC) - 1;
        longint s = 0;
        int mn = (1 << NX) - 1;
        int mx = 0;
        bit o = 1'b0;
        foreach (win[i]) begin
            s = s + win[i];
            if (s > lim) begin
                o = 1'b1;
`ifdef IF_COLLECT_SATURATE_EN
                s = lim;
`else
                s = s - (lim + 1);
`endif
            end
            if (win[i] < mn) mn = win[i];
            if (win[i] > mx) mx = win[i];
        end
        return rec(s, mn, mx, win.size(), o);
    endfunction

    task automatic test_reset();
        RST_N = 1'b0;
        drive(0, '0, 0, 1);
        #3;
        tests_run++;
        if (observed() !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", observed());
        end
        tests_run++;
        if (XIN_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_xin_ready: got %b expected 1", XIN_READY);
        end
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        tests_run++;
        if (XIN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_reset: got ready=%b valid=%b expected ready=1 valid=0",
                     XIN_READY, OUT_VALID);
        end
    endtask

    task automatic test_window_fill();
        drive(1, 16'd5, 0, 1); tick();
        drive(1, 16'd3, 0, 1); tick();
        drive(1, 16'd9, 0, 1); tick();
        tests_run++;
        if (OUT_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_early_valid: got %b expected 0", OUT_VALID);
        end
        drive(1, 16'd1, 0, 1); tick();
        drive(0, '0, 0, 1);
        tests_run++;
        if (observed() !== rec(18, 1, 9, 4, 0)) begin
            tests_failed++;
            $display("FAIL fill_record: got %h expected %h", observed(), rec(18, 1, 9, 4, 0));
        end
        tests_run++;
        if (XIN_READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_hold_ready: got %b expected 0", XIN_READY);
        end
        tick();
        tests_run++;
        if (XIN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_release: got ready=%b valid=%b expected ready=1 valid=0",
                     XIN_READY, OUT_VALID);
        end
    endtask

    task automatic test_flush();
        drive(1, 16'd7, 0, 1); tick();
        drive(1, 16'd2, 0, 1); tick();
        drive(0, '0, 1, 1); tick();
        drive(0, '0, 0, 1);
        tests_run++;
        if (observed() !== rec(9, 2, 7, 2, 0)) begin
            tests_failed++;
            $display("FAIL flush_alone: got %h expected %h", observed(), rec(9, 2, 7, 2, 0));
        end
        tick();
        drive(1, 16'd4, 1, 1); tick();
        drive(0, '0, 0, 1);
        tests_run++;
        if (observed() !== rec(4, 4, 4, 1, 0)) begin
            tests_failed++;
            $display("FAIL flush_with_sample: got %h expected %h", observed(), rec(4, 4, 4, 1, 0));
        end
        tick();
    endtask

    task automatic test_backpressure();
        for (int i = 1; i <= 4; i++) begin
            drive(1, NX'(i), 0, 0);
            tick();
        end
        drive(1, 16'd100, 1, 0);
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (observed() !== rec(10, 1, 4, 4, 0) || XIN_READY !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold[%0d]: got %h ready=%b expected %h ready=0",
                         i, observed(), XIN_READY, rec(10, 1, 4, 4, 0));
            end
            if (i < 5) tick();
        end
        drive(1, 16'd100, 0, 1); tick();
        drive(1, 16'd10, 0, 1); tick();
        drive(1, 16'd10, 1, 1); tick();
        drive(0, '0, 0, 1);
        tests_run++;
        if (observed() !== rec(20, 10, 10, 2, 0)) begin
            tests_failed++;
            $display("FAIL backpressure_next_window: got %h expected %h",
                     observed(), rec(20, 10, 10, 2, 0));
        end
        tick();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'hFFFF, 0, 1);
            tick();
        end
        drive(0, '0, 0, 1);
        tests_run++;
        if (observed() !== rec(OVF4_SUM, 16'hFFFF, 16'hFFFF, 4, 1)) begin
            tests_failed++;
            $display("FAIL overflow: got %h expected %h",
                     observed(), rec(OVF4_SUM, 16'hFFFF, 16'hFFFF, 4, 1));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 16'd50, 0, 1); tick();
        drive(1, 16'd60, 0, 1); tick();
        drive(0, '0, 0, 1);
        #1 RST_N = 1'b0;
        #1;
        tests_run++;
        if (observed() !== '0 || XIN_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got %h ready=%b expected 0 ready=1",
                     observed(), XIN_READY);
        end
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'd1, 0, 1);
            tick();
        end
        drive(0, '0, 0, 1);
        tests_run++;
        if (observed() !== rec(4, 1, 1, 4, 0)) begin
            tests_failed++;
            $display("FAIL reset_mid_window: got %h expected %h", observed(), rec(4, 1, 1, 4, 0));
        end
        tick();
    endtask

    task automatic test_ignored_flush();
        drive(0, '0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (OUT_VALID !== 1'b0) begin
                tests_failed++;
                $display("FAIL empty_flush[%0d]: got valid=%b expected 0", i, OUT_VALID);
            end
        end
        drive(1, 16'd6, 0, 1); tick();
        drive(1, 16'd8, 0, 1); tick();
        drive(0, '0, 1, 0); tick();
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (observed() !== rec(14, 6, 8, 2, 0)) begin
                tests_failed++;
                $display("FAIL hold_flush[%0d]: got %h expected %h",
                         i, observed(), rec(14, 6, 8, 2, 0));
            end
            tick();
        end
        drive(0, '0, 0, 1); tick();
        drive(0, '0, 1, 1); tick();
        drive(0, '0, 0, 1);
        tests_run++;
        if (OUT_VALID !== 1'b0 || XIN_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_flush_after: got valid=%b ready=%b expected valid=0 ready=1",
                     OUT_VALID, XIN_READY);
        end
    endtask

    task automatic test_random();
        bit hold = 1'b0;
        logic [RW-1:0] exp_rec = '0;
        logic v, f, r;
        logic [NX-1:0] x;
        win.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            x = ($urandom_range(0, 3) == 0) ? NX'($urandom_range(0, 15)) : NX'($urandom);
            f = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 2) != 0);
            drive(v, x, f, r);
            if (!hold) begin
                if (v) win.push_back(int'(x));
                if (win.size() == WINDOW || (f && win.size() > 0)) begin
                    exp_rec = summarize();
                    win.delete();
                    hold = 1'b1;
                end
            end else if (r) begin
                hold = 1'b0;
            end
            tick();
            tests_run++;
            if (OUT_VALID !== hold || XIN_READY !== !hold ||
                (hold && observed() !== exp_rec)) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %h ready=%b expected valid=%b %h ready=%b",
                         cyc, observed(), XIN_READY, hold, exp_rec, !hold);
            end
        end
        drive(0, '0, 0, 1);
        tick();
    endtask

    initial begin
        test_reset();
        test_window_fill();
        test_flush();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_ignored_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
